// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
//
// Purpose: sits in the MEM stage between the pipeline and main memory. Load
// hits complete in the same cycle; load misses and every store run a
// MemReq/MemAck transaction and stall the pipeline through CacheReady.
//
// Ports:
//   CLK, reset              clock, synchronous active-high reset
//   MemReadM, MemWriteM     load / store present in MEM (store wins if both)
//   ALUOutM, WriteDataM     byte address and store data, stable while stalled
//   ReadDataM, CacheReady   load data and access-complete indication
//   MemReq, MemWE, MemAddr,
//   MemWData                memory request, held until MemAck
//   MemRData, MemAck        memory read data and one-cycle completion pulse

module dcache_ctrl #(
  parameter int INDEX_BITS = 6
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        CacheReady,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:0]           fill_q;
  logic                  done_rd_q;
  logic                  req_q;
  logic                  we_q;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  rd_miss;
  logic [1:0]            unused_byte_off;

  assign index           = ALUOutM[INDEX_BITS+1:2];
  assign tag             = ALUOutM[31:INDEX_BITS+2];
  assign unused_byte_off = ALUOutM[1:0];
  assign hit             = valid_q[index] && (tag_q[index] == tag);

  // A store always takes priority when both strobes are (illegally) high.
  assign wr_acc  = MemWriteM;
  assign rd_acc  = MemReadM & ~MemWriteM;
  assign rd_miss = rd_acc & ~hit;

  // Control FSM; request outputs are registered so they rise on the first
  // wait-state cycle and drop on the edge that consumes MemAck.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      fill_q    <= '0;
      done_rd_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_acc) begin
            state_q <= S_WR_WAIT;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
          end else if (rd_miss) begin
            state_q <= S_RD_WAIT;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
          end
        end
        S_RD_WAIT: begin
          if (MemAck) begin
            valid_q[index] <= 1'b1;
            fill_q         <= MemRData;
            done_rd_q      <= 1'b1;
            req_q          <= 1'b0;
            state_q        <= S_DONE;
          end
        end
        S_WR_WAIT: begin
          if (MemAck) begin
            done_rd_q <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify them.
  // A store updates the line only if it is resident (no write-allocate).
  always_ff @(posedge CLK) begin
    if (!reset && MemAck) begin
      if (state_q == S_RD_WAIT) begin
        tag_q[index]  <= tag;
        data_q[index] <= MemRData;
      end else if (state_q == S_WR_WAIT && hit) begin
        data_q[index] <= WriteDataM;
      end
    end
  end

  // CacheReady must be combinational so a load hit completes with no stall.
  always_comb begin
    CacheReady = 1'b0;
    ReadDataM  = '0;
    if (reset) begin
      CacheReady = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          CacheReady = ~(wr_acc | rd_miss);
          if (rd_acc && hit) begin
            ReadDataM = data_q[index];
          end
        end
        S_DONE: begin
          CacheReady = 1'b1;
          if (done_rd_q) begin
            ReadDataM = fill_q;
          end
        end
        default: begin
          CacheReady = 1'b0;
        end
      endcase
    end
  end

  assign MemReq   = req_q & ~reset;
  assign MemWE    = we_q & MemReq;
  assign MemAddr  = {ALUOutM[31:2], 2'b00};
  assign MemWData = WriteDataM;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl

module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        CacheReady;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  always #5 CLK = ~CLK;

  dcache_ctrl #(.INDEX_BITS(6)) dut (
    .CLK(CLK), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .CacheReady(CacheReady),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck)
  );

  int total = 0;
  int bad   = 0;

  logic        exp_ready, exp_req, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;

  // Length of the most recent CacheReady-low run and the data seen when it ended.
  int          run = 0;
  int          last_stall = 0;
  logic [31:0] last_rdata = '0;

  // Reference model: the cache as a table of resident words, memory as a map.
  bit          mv    [64];
  logic [23:0] mtag  [64];
  logic [31:0] mdata [64];
  logic [31:0] mem   [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    if (!mem.exists(w)) mem[w] = $urandom;
    return mem[w];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, expv);
    end
  endtask

  task automatic set_exp(input logic r, input logic q, input logic we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    exp_ready = r; exp_req = q; exp_we = we;
    exp_addr = a; exp_wdata = wd; exp_rdata = rd;
  endtask

  // One clock: compare outputs on the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge CLK);
    chk("CacheReady", 32'(CacheReady), 32'(exp_ready));
    chk("MemReq", 32'(MemReq), 32'(exp_req));
    chk("ReadDataM", ReadDataM, exp_rdata);
    if (exp_req) begin
      chk("MemWE", 32'(MemWE), 32'(exp_we));
      chk("MemAddr", MemAddr, exp_addr);
      if (exp_we) chk("MemWData", MemWData, exp_wdata);
    end
    if (CacheReady) begin
      last_stall = run;
      last_rdata = ReadDataM;
      run = 0;
    end else begin
      run++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = $urandom; WriteDataM = $urandom;
    MemAck = 1'($urandom_range(0, 1)); MemRData = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step();
    MemAck = 1'b0;
  endtask

  // One MEM-stage access; memory acks on wait cycle 'lat', or reset is
  // raised on wait cycle 'rst_at' (0 = never).
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input int rst_at);
    logic [29:0] w;
    logic [5:0]  idx;
    logic [23:0] tg;
    bit          hit;
    logic [31:0] rv;
    w = a[31:2]; idx = a[7:2]; tg = a[31:8];
    hit = mv[idx] && (mtag[idx] == tg);
    MemReadM = rd; MemWriteM = wr; ALUOutM = a; WriteDataM = wd;
    MemAck = 1'($urandom_range(0, 1)); MemRData = $urandom;
    if (!wr && !rd) begin
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, '0);
      step(); MemAck = 1'b0;
      return;
    end
    if (!wr && hit) begin
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, mdata[idx]);
      step(); MemAck = 1'b0;
      return;
    end
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    rv = wr ? 32'h0 : mem_rd(w);
    for (int c = 1; c <= lat; c++) begin
      if (c == rst_at) begin
        reset = 1'b1; MemAck = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, '0, '0, '0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        return;
      end
      MemAck = (c == lat);
      MemRData = wr ? $urandom : rv;
      set_exp(1'b0, 1'b1, wr, {w, 2'b00}, wd, '0);
      step();
    end
    MemAck = 1'($urandom_range(0, 1)); MemRData = $urandom;
    if (wr) begin
      mem[w] = wd;
      if (hit) mdata[idx] = wd;
    end else begin
      mv[idx] = 1'b1; mtag[idx] = tg; mdata[idx] = rv;
    end
    set_exp(1'b1, 1'b0, 1'b0, '0, '0, wr ? 32'h0 : rv);
    step();
    MemAck = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          k, lat, rst;
    bit          rd, wr;

    reset = 1'b1; MemReadM = 1'b0; MemWriteM = 1'b0;
    ALUOutM = '0; WriteDataM = '0; MemRData = '0; MemAck = 1'b0;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, '0, '0, '0);
    step();
    step();
    reset = 1'b0;
    idle();

    // Cold read miss, ack on third wait cycle, then a same-cycle hit.
    mem[30'h10] = 32'hDEADBEEF;
    access(1, 0, 32'h0000_0040, 32'h0, 3, 0);
    chk("cold_stall", 32'(last_stall), 32'd4);
    chk("cold_data", last_rdata, 32'hDEADBEEF);
    access(1, 0, 32'h0000_0040, 32'h0, 1, 0);
    chk("hit_stall", 32'(last_stall), 32'd0);
    chk("hit_data", last_rdata, 32'hDEADBEEF);

    // Store to resident line updates it.
    access(0, 1, 32'h0000_0040, 32'h12345678, 2, 0);
    chk("store_stall", 32'(last_stall), 32'd3);
    chk("store_rdata", last_rdata, 32'h0);
    access(1, 0, 32'h0000_0040, 32'h0, 1, 0);
    chk("upd_hit_stall", 32'(last_stall), 32'd0);
    chk("upd_hit_data", last_rdata, 32'h12345678);

    // Store to non-resident line does not allocate.
    access(0, 1, 32'h0000_0080, 32'hCAFEF00D, 1, 0);
    chk("min_store_stall", 32'(last_stall), 32'd2);
    access(1, 0, 32'h0000_0080, 32'h0, 1, 0);
    chk("noalloc_stall", 32'(last_stall), 32'd2);
    chk("noalloc_data", last_rdata, 32'hCAFEF00D);

    // Aliasing on index 16.
    access(1, 0, 32'h0000_0140, 32'h0, 1, 0);
    chk("alias_stall", 32'(last_stall), 32'd2);
    access(1, 0, 32'h0000_0040, 32'h0, 1, 0);
    chk("alias_back_stall", 32'(last_stall), 32'd2);
    chk("alias_back_data", last_rdata, 32'h12345678);

    // Reset during a read wait drops the request and invalidates 0x40.
    access(1, 0, 32'h0000_00C0, 32'h0, 3, 2);
    access(1, 0, 32'h0000_0040, 32'h0, 1, 0);
    chk("post_reset_stall", 32'(last_stall), 32'd2);

    // Both strobes high behaves as a store.
    access(1, 1, 32'h0000_0044, 32'h5555AAAA, 1, 0);
    chk("both_rdata", last_rdata, 32'h0);
    chk("both_stall", 32'(last_stall), 32'd2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) idle();
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a[31:28] = 4'($urandom);
      k   = int'($urandom_range(0, 9));
      rd  = (k < 6) || (k == 9);
      wr  = (k >= 6);
      lat = int'($urandom_range(1, 4));
      rst = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, lat)) : 0;
      access(rd, wr, a, $urandom, lat, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
